// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI NOR flash burst reader.
package spi_flash_pkg;

  localparam int         ADDR_W        = 24;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    INIT_WAIT,
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    DONE
  } state_e;

endpackage

// File: rtl/spi_flash_burst_reader_shift.sv
// One SPI mode-0 bit stream: SCLK divider, MSB-first shift-out and byte shift-in.
module spi_shift_engine #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        run_i,
  input  logic        load_i,
  input  logic        capture_i,
  input  logic [23:0] tx_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        bit_done_o,
  output logic        byte_done_o,
  output logic [7:0]  byte_o
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic [23:0]   tx_q, tx_d;
  logic [6:0]    rx_q, rx_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          done_q, done_d;
  logic          tick, rise, fall;

  assign tick = run_i && (div_q == '0);
  assign rise = tick && !sclk_q;
  assign fall = tick && sclk_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    bit_d  = bit_q;
    byte_d = byte_q;
    done_d = 1'b0;
    if (start_i) begin
      div_d  = DIV_LAST;
      sclk_d = 1'b0;
      tx_d   = tx_i;
      bit_d  = '0;
    end else if (run_i) begin
      div_d = tick ? DIV_LAST : div_q - 1'b1;
      if (tick) sclk_d = !sclk_q;
      // MOSI only moves on the falling edge; a load replaces the shift at segment boundaries
      if (fall) tx_d = load_i ? tx_i : {tx_q[22:0], 1'b0};
      if (rise && capture_i) begin
        rx_d  = {rx_q[5:0], miso_i};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) begin
          byte_d = {rx_q, miso_i};
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      tx_q   <= '0;
      rx_q   <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      done_q <= done_d;
    end
  end

  assign sclk_o      = sclk_q;
  assign mosi_o      = tx_q[23];
  assign bit_done_o  = fall;
  assign byte_done_o = done_q;
  assign byte_o      = byte_q;

endmodule

// File: rtl/spi_flash_burst_reader.sv
// SPI NOR flash burst reader: READ/FAST_READ of BURST_BYTES bytes into a wide buffer.
// State | meaning: INIT_WAIT power-up wait | IDLE ready | CMD opcode | ADDR 24-bit address
//                  DUMMY fast-read dummy byte | READ capture bytes | DONE buffer valid
module spi_flash_burst_reader
  import spi_flash_pkg::*;
#(
  parameter int STARTUP_WAIT = 2700000,
  parameter int CLK_DIV      = 1,
  parameter int BURST_BYTES  = 32,
  parameter int FAST_READ    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     flashClk,
  input  logic                     flashMiso,
  output logic                     flashMosi,
  output logic                     flashCs,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic [8*BURST_BYTES-1:0] f_dataBuffer,
  output logic                     f_dataAvailable,
  input  logic                     f_readyToRead,
  output logic                     byte_valid,
  output logic [7:0]               byte_data,
  output logic                     busy
);

  localparam int             CW        = $clog2(STARTUP_WAIT + 2);
  localparam logic [CW-1:0]  INIT_LAST = CW'(STARTUP_WAIT);
  localparam int             SLW       = (BURST_BYTES > 1) ? $clog2(BURST_BYTES) : 1;
  localparam logic [11:0]    SEG_CMD   = 12'd7;
  localparam logic [11:0]    SEG_ADDR  = 12'd23;
  localparam logic [11:0]    SEG_DUMMY = 12'd7;
  localparam logic [11:0]    SEG_READ  = 12'(8 * BURST_BYTES - 1);
  localparam logic [7:0]     OPCODE    = (FAST_READ != 0) ? CMD_FAST_READ : CMD_READ;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [11:0]              seg_q, seg_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     cs_q, cs_d;
  logic [SLW-1:0]           slot_q, slot_d;
  logic [8*BURST_BYTES-1:0] buf_q, buf_d;

  logic              start, load, run, capture, seg_end;
  logic [ADDR_W-1:0] tx;
  logic              sclk, mosi, bit_done, byte_done;
  logic [7:0]        byte_rx;

  assign run     = (state_q == CMD) || (state_q == ADDR) || (state_q == DUMMY) || (state_q == READ);
  assign capture = (state_q == READ);
  assign seg_end = bit_done && (seg_q == '0);

  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .run_i      (run),
    .load_i     (load),
    .capture_i  (capture),
    .tx_i       (tx),
    .miso_i     (flashMiso),
    .sclk_o     (sclk),
    .mosi_o     (mosi),
    .bit_done_o (bit_done),
    .byte_done_o(byte_done),
    .byte_o     (byte_rx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    addr_d  = addr_q;
    cs_d    = cs_q;
    slot_d  = slot_q;
    buf_d   = buf_q;
    start   = 1'b0;
    load    = 1'b0;
    tx      = '0;
    if (byte_done) begin
      buf_d[8*int'(slot_q) +: 8] = byte_rx;
      slot_d = slot_q + 1'b1;
    end
    if (bit_done && (seg_q != '0)) seg_d = seg_q - 1'b1;
    // Each segment hands over on the falling edge after its last bit; MOSI is 0 after the address
    case (state_q)
      INIT_WAIT: begin
        if (cnt_q > INIT_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      IDLE: begin
        if (req_valid) begin
          start   = 1'b1;
          tx      = {OPCODE, 16'h0000};
          addr_d  = req_addr;
          seg_d   = SEG_CMD;
          cs_d    = 1'b0;
          slot_d  = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        if (seg_end) begin
          load    = 1'b1;
          tx      = addr_q;
          seg_d   = SEG_ADDR;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (seg_end) begin
          load = 1'b1;
          if (FAST_READ != 0) begin
            seg_d   = SEG_DUMMY;
            state_d = DUMMY;
          end else begin
            seg_d   = SEG_READ;
            state_d = READ;
          end
        end
      end
      DUMMY: begin
        if (seg_end) begin
          load    = 1'b1;
          seg_d   = SEG_READ;
          state_d = READ;
        end
      end
      READ: begin
        if (seg_end) begin
          load    = 1'b1;
          cs_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (f_readyToRead) state_d = IDLE;
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_WAIT;
      cnt_q   <= '0;
      seg_q   <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b1;
      slot_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
    end
  end

  assign flashClk        = sclk;
  assign flashMosi       = mosi;
  assign flashCs         = cs_q;
  assign req_ready       = (state_q == IDLE);
  assign f_dataAvailable = (state_q == DONE);
  assign f_dataBuffer    = buf_q;
  assign byte_valid      = byte_done;
  assign byte_data       = byte_rx;
  assign busy            = run;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench: three reader configurations, each driven against a small SPI flash model.
`timescale 1ns/1ps
module tb_spi_flash_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  rv_v  = 3'b000;
  logic [2:0]  rtr_v = 3'b000;
  logic [23:0] addr_v [3];
  logic [7:0]  dbase  [3];

  logic [2:0]  w_fclk, w_mosi, w_cs, w_rdy, w_dav, w_bval, w_busy;
  logic [7:0]  w_bdata [3];
  logic [31:0] w_buf   [3];
  logic [39:0] w_cap   [3];
  int          w_rises [3];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic data_bit(input logic [7:0] base, input int idx);
    logic [7:0] b;
    b = base + 8'(idx / 8);
    return b[7 - (idx % 8)];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int DIV = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
    localparam int BB  = (g == 0) ? 4 : ((g == 2) ? 1 : 2);
    localparam int FR  = (g == 1) ? 1 : 0;
    localparam int HDR = 32 + 8 * FR;

    logic            fclk, cs, mosi, rdy, dav, bval, busy;
    logic            miso_r = 1'b0;
    logic [7:0]      bdata;
    logic [8*BB-1:0] buf_l;
    logic [39:0]     cap   = '0;
    int              rises = 0;

    spi_flash_burst_reader #(
      .STARTUP_WAIT(10), .CLK_DIV(DIV), .BURST_BYTES(BB), .FAST_READ(FR)
    ) u_dut (
      .clk            (clk),
      .rst            (rst_v[g]),
      .flashClk       (fclk),
      .flashMiso      (miso_r),
      .flashMosi      (mosi),
      .flashCs        (cs),
      .req_valid      (rv_v[g]),
      .req_addr       (addr_v[g]),
      .req_ready      (rdy),
      .f_dataBuffer   (buf_l),
      .f_dataAvailable(dav),
      .f_readyToRead  (rtr_v[g]),
      .byte_valid     (bval),
      .byte_data      (bdata),
      .busy           (busy)
    );

    always @(negedge cs) begin
      rises <= 0;
      cap   <= '0;
    end
    always @(posedge fclk) begin
      if (!cs) begin
        if (rises < 40) cap <= {cap[38:0], mosi};
        rises <= rises + 1;
      end
    end
    always @(negedge fclk) begin
      if (!cs && rises >= HDR && rises < HDR + 8 * BB)
        miso_r <= data_bit(dbase[g], rises - HDR);
    end

    assign w_fclk[g]  = fclk;
    assign w_mosi[g]  = mosi;
    assign w_cs[g]    = cs;
    assign w_rdy[g]   = rdy;
    assign w_dav[g]   = dav;
    assign w_bval[g]  = bval;
    assign w_busy[g]  = busy;
    assign w_bdata[g] = bdata;
    assign w_buf[g]   = 32'(buf_l);
    assign w_cap[g]   = cap;
    assign w_rises[g] = rises;
  end

  typedef struct {
    int          inst;
    int          div;
    int          fast;
    int          nb;
    logic [23:0] addr;
    logic [7:0]  dbase;
    int          lat;
    logic [39:0] cap;
    logic [31:0] bufv;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with reset asserted on the instances in mask and the last edge a reset edge.
  task automatic power_up(input logic [2:0] mask);
    int first [3];
    int quiet_bad, dav_seen;
    quiet_bad = 0;
    dav_seen  = 0;
    for (int g = 0; g < 3; g++) first[g] = 0;
    rst_v = rst_v & ~mask;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        if (mask[g]) begin
          if (first[g] == 0 && w_rdy[g]) first[g] = cyc;
          if (first[g] == 0 && {w_cs[g], w_fclk[g], w_mosi[g]} != 3'b100) quiet_bad++;
          if (w_dav[g]) dav_seen++;
        end
      end
    end
    for (int g = 0; g < 3; g++)
      if (mask[g]) check($sformatf("ready_rise_cycle[%0d]", g), first[g], 12);
    check("pins_quiet_in_init", quiet_bad, 0);
    check("no_dav_in_init", dav_seen, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int g, n, cyc, first_rise, highs, nbv, bv_bad, stable_bad;
    g = v.inst;
    n = 32 + 8 * v.fast + 8 * v.nb;
    dbase[g] = v.dbase;
    check("ready_before", w_rdy[g], 1);
    addr_v[g] = v.addr;
    rv_v[g]   = 1'b1;
    tick();
    rv_v[g]   = 1'b0;
    addr_v[g] = ~v.addr;
    cyc = 1; first_rise = 0; highs = 0; nbv = 0; bv_bad = 0;
    check("pins_after_accept", {w_cs[g], w_fclk[g], w_mosi[g], w_busy[g]}, 4'b0001);
    while (!w_dav[g] && cyc < 2000) begin
      if (w_fclk[g]) begin
        highs++;
        if (first_rise == 0) first_rise = cyc;
      end
      if (w_bval[g]) begin
        if (cyc != 1 + (2 * (32 + 8 * v.fast + 8 * nbv + 8) - 1) * v.div ||
            w_bdata[g] !== v.dbase + 8'(nbv))
          bv_bad++;
        nbv++;
      end
      if (cyc == 20) begin
        rv_v[g]   = 1'b1;
        addr_v[g] = 24'h5A5A5A;
        rtr_v[g]  = 1'b1;
      end
      if (cyc == 23) begin
        rv_v[g]  = 1'b0;
        rtr_v[g] = 1'b0;
      end
      tick();
      cyc++;
    end
    check("latency", cyc, v.lat);
    check("first_rise", first_rise, 1 + v.div);
    check("sclk_high_cycles", highs, n * v.div);
    check("byte_pulses", nbv, v.nb);
    check("byte_timing_data", bv_bad, 0);
    check("mosi_header", w_cap[g], v.cap);
    check("buffer", w_buf[g], v.bufv);
    check("done_pins", {w_cs[g], w_fclk[g], w_busy[g], w_rdy[g]}, 4'b1000);
    stable_bad = 0;
    repeat (50) begin
      tick();
      if (!w_dav[g] || w_buf[g] !== v.bufv || w_rdy[g] || !w_cs[g] || w_fclk[g]) stable_bad++;
    end
    check("hold_stable", stable_bad, 0);
    rtr_v[g] = 1'b1;
    tick();
    rtr_v[g] = 1'b0;
    check("release", {w_dav[g], w_rdy[g]}, 2'b01);
    tick();
    tick();
    check("idle_after", {w_busy[g], w_cs[g], w_buf[g] == v.bufv}, 3'b011);
  endtask

  initial begin
    int cyc;
    for (int g = 0; g < 3; g++) begin
      addr_v[g] = '0;
      dbase[g]  = '0;
    end
    vecs[0] = '{inst: 0, div: 1, fast: 0, nb: 4, addr: 24'h123456, dbase: 8'hA0,
                lat: 129, cap: 40'h03_123456_00, bufv: 32'hA3A2A1A0};
    vecs[1] = '{inst: 0, div: 1, fast: 0, nb: 4, addr: 24'h000001, dbase: 8'h10,
                lat: 129, cap: 40'h03_000001_00, bufv: 32'h13121110};
    vecs[2] = '{inst: 1, div: 3, fast: 1, nb: 2, addr: 24'h00F0A5, dbase: 8'hB0,
                lat: 337, cap: 40'h0B_00F0A5_00, bufv: 32'h0000B1B0};
    vecs[3] = '{inst: 2, div: 2, fast: 0, nb: 1, addr: 24'hFFFFFF, dbase: 8'h5C,
                lat: 161, cap: 40'h03_FFFFFF_00, bufv: 32'h0000005C};

    tick();
    tick();
    check("reset_state", {w_cs, w_fclk, w_mosi, w_rdy, w_dav, w_busy}, {3'b111, 15'b0});
    power_up(3'b111);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset in the middle of a burst on instance 0
    dbase[0]  = 8'h77;
    addr_v[0] = 24'h00ABCD;
    rv_v[0]   = 1'b1;
    tick();
    rv_v[0]   = 1'b0;
    cyc = 0;
    while (w_rises[0] < 40 && cyc < 500) begin
      tick();
      cyc++;
    end
    check("reached_bit40", w_rises[0], 40);
    rst_v[0] = 1'b1;
    tick();
    check("reset_pins", {w_cs[0], w_fclk[0], w_mosi[0], w_dav[0], w_busy[0], w_rdy[0]}, 6'b100000);
    power_up(3'b001);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
